// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch control for a 5-digit BCD counter: button edges drive a run/lap/pause FSM,
// a prescaler issues count-enable ticks, and the display mux selects live or frozen lap value.
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic        btn_clr,
    input  logic [19:0] count_in,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic [19:0] display,
    output logic        running,
    output logic        lap_active,
    output logic        overflow,
    output logic [1:0]  dbg_state
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_LAP    = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_prev_ss;
    logic          r_prev_lap;
    logic          r_prev_clr;
    logic [PW-1:0] r_presc;
    logic [19:0]   r_lap;
    logic          r_cnt_en;
    logic          r_cnt_clr;
    logic          r_overflow;

    logic          w_ss;
    logic          w_clr;
    logic          w_lap;
    logic          w_do_clear;
    logic          w_lap_capture;
    logic          w_advance;

    // One edge per cycle: start/stop beats clear beats lap; losers are dropped.
    assign w_ss  = btn_ss & ~r_prev_ss;
    assign w_clr = btn_clr & ~r_prev_clr & ~w_ss;
    assign w_lap = btn_lap & ~r_prev_lap & ~w_ss & ~(btn_clr & ~r_prev_clr);

    always_comb begin
        w_state_next  = r_state;
        w_do_clear    = 1'b0;
        w_lap_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ss) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_ss) begin
                    w_state_next = S_PAUSED;
                end else if (w_lap) begin
                    w_state_next  = S_LAP;
                    w_lap_capture = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ss)       w_state_next = S_PAUSED;
                else if (w_lap) w_state_next = S_RUN;
            end
            S_PAUSED: begin
                if (w_ss) begin
                    w_state_next = S_RUN;
                end else if (w_clr) begin
                    w_state_next = S_IDLE;
                    w_do_clear   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Advancing on the next state lets the start edge count and the stop edge suppress a tick.
    assign w_advance = (w_state_next == S_RUN) || (w_state_next == S_LAP);

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state    <= S_IDLE;
            r_prev_ss  <= 1'b1;
            r_prev_lap <= 1'b1;
            r_prev_clr <= 1'b1;
            r_presc    <= '0;
            r_lap      <= '0;
            r_cnt_en   <= 1'b0;
            r_cnt_clr  <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_prev_ss  <= btn_ss;
            r_prev_lap <= btn_lap;
            r_prev_clr <= btn_clr;
            r_cnt_clr  <= w_do_clear;
            r_cnt_en   <= w_advance && (r_presc == PRESC_LAST);
            if (w_do_clear) begin
                r_presc <= '0;
            end else if (w_advance) begin
                if (r_presc == PRESC_LAST) r_presc <= '0;
                else                       r_presc <= r_presc + 1'b1;
            end
            if (w_lap_capture) r_lap <= count_in;
            if (w_do_clear)                              r_overflow <= 1'b0;
            else if (r_cnt_en && count_in == 20'h99999)  r_overflow <= 1'b1;
        end
    end

    assign cnt_en     = r_cnt_en;
    assign cnt_clr    = r_cnt_clr;
    assign running    = (r_state == S_RUN) || (r_state == S_LAP);
    assign lap_active = (r_state == S_LAP);
    assign overflow   = r_overflow;
    assign display    = (r_state == S_LAP) ? r_lap : count_in;
    assign dbg_state  = r_state;

endmodule
